// File: rtl/delay_meter_pkg.sv
// Shared types and defaults for the round-trip delay meter.
// State encoding is fixed (IDLE=0, MEAS=1) so debug probes can read it directly.
package delay_meter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } meter_state_e;

   localparam int DEFAULT_WIDTH      = 16;
   localparam int DEFAULT_MAX_CYCLES = 65535;

endpackage

// File: rtl/delay_meter.sv
// Round-trip latency meter: toggles probe on an accepted start and counts clk
// cycles until echo follows it, reporting the count or a timeout.
module delay_meter
   import delay_meter_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             echo,
   output logic             probe,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_CYCLES);

   meter_state_e     state;
   meter_state_e     state_next;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] result_next;
   logic             probe_next;
   logic             busy_next;
   logic             done_next;
   logic             timeout_next;
   logic             err_next;
   logic             settled;

   // The path is settled once echo has caught up with the current probe level.
   assign settled = (echo == probe);

   // Next-state and output decisions; echo is checked before the limit so a
   // return on the final allowed cycle still counts as a real measurement.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      result_next  = result;
      probe_next   = probe;
      busy_next    = busy;
      timeout_next = timeout;
      done_next    = 1'b0;
      err_next     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (settled) begin
                  probe_next   = ~probe;
                  cnt_next     = '0;
                  busy_next    = 1'b1;
                  timeout_next = 1'b0;
                  result_next  = '0;
                  state_next   = ST_MEAS;
               end else begin
                  err_next = 1'b1;
               end
            end
         end

         ST_MEAS: begin
            if (settled) begin
               result_next = cnt;
               done_next   = 1'b1;
               busy_next   = 1'b0;
               state_next  = ST_IDLE;
            end else if (cnt == LIMIT) begin
               result_next  = LIMIT;
               timeout_next = 1'b1;
               done_next    = 1'b1;
               busy_next    = 1'b0;
               state_next   = ST_IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // All outputs are registered; reset aborts any run without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         result  <= '0;
         probe   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         result  <= result_next;
         probe   <= probe_next;
         busy    <= busy_next;
         done    <= done_next;
         timeout <= timeout_next;
         err     <= err_next;
      end
   end

endmodule
